// File: rtl/lt24_write_sequencer.sv
// LT24 LCD write sequencer.
// Runs the panel power-up reset timing, then arbitrates between a command
// channel and a pixel-burst channel and drives 8080-style write cycles.
// Once a pixel burst has started it owns the bus until its last word.
// Between bursts, commands have fixed priority over pixels.
module lt24_write_sequencer #(
    parameter int WR_LOW_CYCLES    = 2,
    parameter int WR_HIGH_CYCLES   = 2,
    parameter int RST_PULSE_CYCLES = 500,
    parameter int RST_WAIT_CYCLES  = 6000000,
    parameter int CNT_W            = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init_start,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    input  logic        cmd_is_param,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    input  logic        pix_last,
    output logic        busy,
    output logic        init_done,
    output logic        lcd_on,
    output logic        lcd_reset_n,
    output logic        cs_n,
    output logic        wr_n,
    output logic        rd_n,
    output logic        dc_n,
    output logic [15:0] d
);

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_IDLE,
        ST_WR_LOW,
        ST_WR_HIGH
    } state_t;

    // Terminal counts: each timed state lasts (last + 1) clocks.
    localparam logic [CNT_W-1:0] LP_PULSE_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_WAIT_LAST  = CNT_W'(RST_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_LOW_LAST   = CNT_W'(WR_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_HIGH_LAST  = CNT_W'(WR_HIGH_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_d;
    logic               r_dc_n;
    logic               r_burst_lock;
    logic               r_init_done;
    logic               r_lcd_on;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_cmd_ready;
    logic               w_pix_ready;
    logic               w_cmd_acc;
    logic               w_pix_acc;
    logic               w_init_go;
    logic               w_init_set;
    logic               w_cs_n;
    logic               w_wr_n;

    // Next-state, handshake and bus-strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement leaves a signal unassigned (no latches).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cmd_ready = 1'b0;
        w_pix_ready = 1'b0;
        w_cmd_acc   = 1'b0;
        w_pix_acc   = 1'b0;
        w_init_go   = 1'b0;
        w_init_set  = 1'b0;
        w_cs_n      = 1'b1;
        w_wr_n      = 1'b1;

        unique case (r_state)
            ST_RST_LOW: begin
                if (r_cnt == LP_PULSE_LAST) begin
                    w_state_nxt = ST_RST_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_RST_WAIT: begin
                if (r_cnt == LP_WAIT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_init_set  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_IDLE: begin
                // Chip select stays low between the words of a pixel burst.
                w_cs_n = ~r_burst_lock;
                if (init_start) begin
                    // Re-init wins over any waiting requester; nothing is
                    // accepted this cycle, requesters simply keep waiting.
                    w_init_go   = 1'b1;
                    w_state_nxt = ST_RST_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    if (r_burst_lock) begin
                        w_pix_ready = 1'b1;
                    end else begin
                        w_cmd_ready = 1'b1;
                        w_pix_ready = ~cmd_valid;
                    end
                    w_cmd_acc = cmd_valid & w_cmd_ready;
                    w_pix_acc = pix_valid & w_pix_ready;
                    if (w_cmd_acc || w_pix_acc) begin
                        w_state_nxt = ST_WR_LOW;
                        w_cnt_nxt   = '0;
                        w_cs_n      = 1'b0;
                    end
                end
            end

            ST_WR_LOW: begin
                w_cs_n = 1'b0;
                w_wr_n = 1'b0;
                if (r_cnt == LP_LOW_LAST) begin
                    w_state_nxt = ST_WR_HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_WR_HIGH: begin
                w_cs_n = 1'b0;
                if (init_start) begin
                    // The write already has its rising edge; cutting the
                    // recovery time short is harmless because the panel is
                    // about to be reset anyway.
                    w_init_go   = 1'b1;
                    w_state_nxt = ST_RST_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_HIGH_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_RST_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register and shared timing counter.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset_n) begin
            r_state <= ST_RST_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Bus data/dc_n capture, burst ownership, init status and power enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d          <= '0;
            r_dc_n       <= 1'b1;
            r_burst_lock <= 1'b0;
            r_init_done  <= 1'b0;
            r_lcd_on     <= 1'b0;
        end else begin
            r_lcd_on <= 1'b1;

            if (w_cmd_acc) begin
                r_d    <= cmd_data;
                r_dc_n <= cmd_is_param;
            end else if (w_pix_acc) begin
                r_d    <= pix_data;
                r_dc_n <= 1'b1;
            end

            if (w_init_go) begin
                r_burst_lock <= 1'b0;
            end else if (w_pix_acc) begin
                r_burst_lock <= ~pix_last;
            end

            if (w_init_go) begin
                r_init_done <= 1'b0;
            end else if (w_init_set) begin
                r_init_done <= 1'b1;
            end
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign pix_ready   = w_pix_ready;
    assign busy        = (r_state != ST_IDLE);
    assign init_done   = r_init_done;
    assign lcd_on      = r_lcd_on;
    assign lcd_reset_n = (r_state != ST_RST_LOW);
    assign cs_n        = w_cs_n;
    assign wr_n        = w_wr_n;
    assign rd_n        = 1'b1;
    assign dc_n        = r_dc_n;
    assign d           = r_d;

endmodule

// File: tb/tb_lt24_write_sequencer.sv
// Self-checking bench for lt24_write_sequencer: a cycle table for power-up
// and a single command, hand-written multi-cycle sequences, and a random
// phase checked against a transaction-timing model.
module tb_lt24_write_sequencer;

    localparam int WR_LOW      = 2;
    localparam int WR_HIGH     = 1;
    localparam int PULSE       = 4;
    localparam int WAITC       = 8;
    localparam int RAND_CYCLES = 400;

    logic        clk          = 1'b0;
    logic        reset_n      = 1'b0;
    logic        init_start   = 1'b0;
    logic        cmd_valid    = 1'b0;
    logic [15:0] cmd_data     = '0;
    logic        cmd_is_param = 1'b0;
    logic        pix_valid    = 1'b0;
    logic [15:0] pix_data     = '0;
    logic        pix_last     = 1'b0;
    logic        cmd_ready, pix_ready, busy, init_done, lcd_on, lcd_reset_n;
    logic        cs_n, wr_n, rd_n, dc_n;
    logic [15:0] d;

    int n_checks = 0;
    int n_fail   = 0;
    int cs_high  = 0;
    bit mon_cs   = 1'b0;

    lt24_write_sequencer #(
        .WR_LOW_CYCLES   (WR_LOW),
        .WR_HIGH_CYCLES  (WR_HIGH),
        .RST_PULSE_CYCLES(PULSE),
        .RST_WAIT_CYCLES (WAITC),
        .CNT_W           (24)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .init_start  (init_start),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .cmd_is_param(cmd_is_param),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .busy        (busy),
        .init_done   (init_done),
        .lcd_on      (lcd_on),
        .lcd_reset_n (lcd_reset_n),
        .cs_n        (cs_n),
        .wr_n        (wr_n),
        .rd_n        (rd_n),
        .dc_n        (dc_n),
        .d           (d)
    );

    always #5 clk = ~clk;

    // Bus monitor: every wr_n rising edge is the panel's latch point.
    typedef struct {
        logic [15:0] dat;
        logic        dc;
        logic        cs;
    } wr_t;
    wr_t bus_log[$];
    always @(posedge wr_n) bus_log.push_back('{d, dc_n, cs_n});

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Advance to the next sampling point (just after the falling edge).
    task automatic tick();
        @(negedge clk);
        #1;
        if (mon_cs && cs_n) cs_high++;
    endtask

    task automatic send_cmd(input logic [15:0] dat, input logic par);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_data = dat; cmd_is_param = par;
        for (int k = 0; k < 40 && !ok; k++) begin
            #1;
            if (cmd_ready) ok = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        check("send_cmd_accepted", ok, 1);
    endtask

    task automatic send_pix(input logic [15:0] dat, input logic last);
        bit ok = 1'b0;
        pix_valid = 1'b1; pix_data = dat; pix_last = last;
        for (int k = 0; k < 40 && !ok; k++) begin
            #1;
            if (pix_ready) ok = 1'b1;
            tick();
        end
        pix_valid = 1'b0; pix_last = 1'b0;
        check("send_pix_accepted", ok, 1);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 60) begin tick(); g++; end
        check("wait_idle", busy, 0);
    endtask

    task automatic wait_log(input int base, input int n);
        int g = 0;
        while (bus_log.size() < base + n && g < 60) begin tick(); g++; end
        check("write_count", bus_log.size() - base, n);
    endtask

    task automatic check_wr(input string nm, input int idx, input logic dc, input logic [15:0] dat);
        if (idx < bus_log.size()) begin
            check({nm, "_d"}, bus_log[idx].dat, dat);
            check({nm, "_dc_n"}, bus_log[idx].dc, dc);
            check({nm, "_cs_n"}, bus_log[idx].cs, 0);
        end else begin
            check({nm, "_present"}, bus_log.size(), idx + 1);
        end
    endtask

    typedef struct {
        logic        cv;
        logic [15:0] cdat;
        logic        cpar;
        logic        cr, pr, busy, idone, lrst, lon, cs, wr, dc;
        logic [15:0] d;
    } vec_t;

    function automatic vec_t mk(input logic cv, input logic [15:0] cdat, input logic cpar,
                                input logic cr, input logic pr, input logic bsy,
                                input logic idone, input logic lrst, input logic lon,
                                input logic cs, input logic wr, input logic dc,
                                input logic [15:0] dd);
        vec_t v;
        v.cv = cv; v.cdat = cdat; v.cpar = cpar;
        v.cr = cr; v.pr = pr; v.busy = bsy; v.idone = idone; v.lrst = lrst;
        v.lon = lon; v.cs = cs; v.wr = wr; v.dc = dc; v.d = dd;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        int   base;

        // Power-up with a command already waiting, then its write cycle.
        //                  cv cdat      p  cr pr by id lr on cs wr dc d
        vecs.push_back(mk(1, 16'h002C, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 16'h0000));
        vecs.push_back(mk(1, 16'h002C, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 16'h0000));
        vecs.push_back(mk(1, 16'h002C, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 16'h0000));
        vecs.push_back(mk(1, 16'h002C, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 16'h0000));
        for (int i = 0; i < WAITC; i++)
            vecs.push_back(mk(1, 16'h002C, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1, 16'h0000));
        vecs.push_back(mk(1, 16'h002C, 0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 16'h0000));
        vecs.push_back(mk(0, 16'h002C, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 16'h002C));
        vecs.push_back(mk(0, 16'h002C, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 16'h002C));
        vecs.push_back(mk(0, 16'h002C, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 16'h002C));
        vecs.push_back(mk(0, 16'h002C, 0, 1, 1, 0, 1, 1, 1, 1, 1, 0, 16'h002C));

        // Reset values while reset_n is held low.
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs_n", cs_n, 1);
        check("rst_wr_n", wr_n, 1);
        check("rst_rd_n", rd_n, 1);
        check("rst_dc_n", dc_n, 1);
        check("rst_d", d, 0);
        check("rst_lcd_reset_n", lcd_reset_n, 0);
        check("rst_lcd_on", lcd_on, 0);
        check("rst_init_done", init_done, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_busy", busy, 1);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            cmd_valid = vecs[i].cv; cmd_data = vecs[i].cdat; cmd_is_param = vecs[i].cpar;
            #1;
            check($sformatf("row%0d_cmd_ready", i), cmd_ready, vecs[i].cr);
            check($sformatf("row%0d_pix_ready", i), pix_ready, vecs[i].pr);
            check($sformatf("row%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("row%0d_init_done", i), init_done, vecs[i].idone);
            check($sformatf("row%0d_lcd_reset_n", i), lcd_reset_n, vecs[i].lrst);
            check($sformatf("row%0d_lcd_on", i), lcd_on, vecs[i].lon);
            check($sformatf("row%0d_cs_n", i), cs_n, vecs[i].cs);
            check($sformatf("row%0d_wr_n", i), wr_n, vecs[i].wr);
            check($sformatf("row%0d_dc_n", i), dc_n, vecs[i].dc);
            check($sformatf("row%0d_d", i), d, vecs[i].d);
            check($sformatf("row%0d_rd_n", i), rd_n, 1);
            tick();
        end
        cmd_valid = 1'b0;

        // Parameter followed by a 3-pixel burst: cs_n held low across it.
        wait_idle();
        base = bus_log.size();
        send_cmd(16'h00EF, 1);
        send_pix(16'hF800, 0);
        cs_high = 0; mon_cs = 1'b1;
        send_pix(16'h07E0, 0);
        send_pix(16'h001F, 1);
        tick(); tick();
        mon_cs = 1'b0;
        tick();
        check("burst_cs_low_between", cs_high, 0);
        check("burst_cs_released", cs_n, 1);
        wait_log(base, 4);
        check_wr("burst_w0", base + 0, 1, 16'h00EF);
        check_wr("burst_w1", base + 1, 1, 16'hF800);
        check_wr("burst_w2", base + 2, 1, 16'h07E0);
        check_wr("burst_w3", base + 3, 1, 16'h001F);

        // Simultaneous requests in IDLE: command goes first.
        wait_idle();
        base = bus_log.size();
        cmd_valid = 1'b1; cmd_data = 16'h0036; cmd_is_param = 1'b0;
        pix_valid = 1'b1; pix_data = 16'h1234; pix_last = 1'b1;
        #1;
        check("arb_cmd_ready", cmd_ready, 1);
        check("arb_pix_ready", pix_ready, 0);
        tick();
        cmd_valid = 1'b0;
        send_pix(16'h1234, 1);
        wait_log(base, 2);
        check_wr("arb_w0", base + 0, 0, 16'h0036);
        check_wr("arb_w1", base + 1, 1, 16'h1234);

        // Command arriving mid-burst waits for pix_last; stalls keep cs_n low.
        wait_idle();
        base = bus_log.size();
        send_pix(16'hAAAA, 0);
        cmd_valid = 1'b1; cmd_data = 16'h002A; cmd_is_param = 1'b0;
        cs_high = 0; mon_cs = 1'b1;
        begin
            logic [15:0] words [2];
            int pi = 0, stall = 2, early = 0, g = 0;
            bit ok = 1'b0;
            words[0] = 16'hBBBB; words[1] = 16'hCCCC;
            while (pi < 2 && g < 80) begin
                pix_valid = (stall == 0); pix_data = words[pi]; pix_last = (pi == 1);
                #1;
                if (cmd_ready) early++;
                if (pix_valid && pix_ready) begin pi++; stall = 2; end
                else if (stall > 0) stall--;
                tick(); g++;
            end
            pix_valid = 1'b0; pix_last = 1'b0; mon_cs = 1'b0;
            check("midburst_cmd_blocked", early, 0);
            check("midburst_pixels_sent", pi, 2);
            check("midburst_cs_low", cs_high, 0);
            for (int k = 0; k < 40 && !ok; k++) begin
                #1;
                if (cmd_ready) ok = 1'b1;
                tick();
            end
            cmd_valid = 1'b0;
            check("midburst_cmd_accepted", ok, 1);
        end
        wait_log(base, 4);
        check_wr("mid_w0", base + 0, 1, 16'hAAAA);
        check_wr("mid_w1", base + 1, 1, 16'hBBBB);
        check_wr("mid_w2", base + 2, 1, 16'hCCCC);
        check_wr("mid_w3", base + 3, 0, 16'h002A);

        // Random traffic against a transaction-timing model.
        wait_idle();
        begin
            int          t = 0, ready_at = 0, last_acc = -100, burst_rem = 0;
            bit          lock = 1'b0, idle, a_c, a_p, e_cr, e_pr, e_cs, e_wr;
            logic [15:0] m_d  = 16'h002A;
            logic        m_dc = 1'b0;
            bit          new_ok;
            while (t < RAND_CYCLES + 300) begin
                new_ok = (t < RAND_CYCLES);
                if (!new_ok && !cmd_valid && !pix_valid && burst_rem == 0) break;
                if (new_ok && !cmd_valid && $urandom_range(2) == 0) begin
                    cmd_valid = 1'b1; cmd_data = 16'($urandom);
                    cmd_is_param = 1'($urandom_range(1));
                end
                if (!pix_valid && (burst_rem > 0 || new_ok) &&
                    (!new_ok || $urandom_range(1) == 0)) begin
                    if (burst_rem == 0) burst_rem = int'($urandom_range(4, 1));
                    pix_valid = 1'b1; pix_data = 16'($urandom);
                    pix_last = (burst_rem == 1);
                end
                #1;
                idle = (t >= ready_at);
                e_cr = idle && !lock;
                e_pr = idle && (lock || !cmd_valid);
                a_c  = cmd_valid && e_cr;
                a_p  = pix_valid && e_pr;
                e_wr = !((t > last_acc) && (t <= last_acc + WR_LOW));
                e_cs = !(!idle || a_c || a_p || lock);
                check("rnd_cmd_ready", cmd_ready, e_cr);
                check("rnd_pix_ready", pix_ready, e_pr);
                check("rnd_busy", busy, !idle);
                check("rnd_cs_n", cs_n, e_cs);
                check("rnd_wr_n", wr_n, e_wr);
                check("rnd_d", d, m_d);
                check("rnd_dc_n", dc_n, m_dc);
                check("rnd_rd_n", rd_n, 1);
                check("rnd_init_done", init_done, 1);
                if (a_c || a_p) begin
                    last_acc = t;
                    ready_at = t + WR_LOW + WR_HIGH + 1;
                    m_d      = a_c ? cmd_data : pix_data;
                    m_dc     = a_c ? cmd_is_param : 1'b1;
                end
                if (a_p) lock = !pix_last;
                tick();
                t++;
                if (a_c) cmd_valid = 1'b0;
                if (a_p) begin pix_valid = 1'b0; pix_last = 1'b0; burst_rem--; end
            end
            check("rnd_drained", int'(cmd_valid) + int'(pix_valid) + burst_rem, 0);
        end

        // Re-init from IDLE with a command pending.
        wait_idle();
        base = bus_log.size();
        init_start = 1'b1;
        cmd_valid = 1'b1; cmd_data = 16'h0011; cmd_is_param = 1'b0;
        #1;
        check("reinit_no_cmd_accept", cmd_ready, 0);
        check("reinit_no_pix_accept", pix_ready, 0);
        tick();
        init_start = 1'b0;
        check("reinit_init_done_cleared", init_done, 0);
        check("reinit_cs_n", cs_n, 1);
        begin
            int lo = 0, hi = 0, early = 0, g = 0;
            while (!init_done && g < 50) begin
                if (!lcd_reset_n) lo++; else hi++;
                if (cmd_ready) early++;
                tick(); g++;
            end
            check("reinit_rst_low_cycles", lo, PULSE);
            check("reinit_wait_cycles", hi, WAITC);
            check("reinit_cmd_held_off", early, 0);
            check("reinit_cmd_ready_after", cmd_ready, 1);
        end
        tick();
        cmd_valid = 1'b0;
        wait_log(base, 1);
        check_wr("reinit_w0", base, 0, 16'h0011);

        // Asynchronous reset in the middle of WR_LOW.
        wait_idle();
        send_cmd(16'h5A5A, 1);
        check("arst_pre_wr_n", wr_n, 0);
        check("arst_pre_cs_n", cs_n, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_wr_n", wr_n, 1);
        check("arst_cs_n", cs_n, 1);
        check("arst_dc_n", dc_n, 1);
        check("arst_d", d, 0);
        check("arst_lcd_reset_n", lcd_reset_n, 0);
        check("arst_init_done", init_done, 0);
        check("arst_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lt24_write_sequencer.md
Name: lt24_write_sequencer

Overview:
- Sequences all write traffic to the LT24 LCD 8080-style parallel bus (cs_n, wr_n, rd_n, dc_n, d[15:0], reset, lcd_on).
- Runs the panel power-up reset timing.
- Arbitrates between two requesters:
  - a command channel from the register interface (command/parameter words);
  - a pixel stream channel (bursts of pixel words).
- Sits between the LT24 Avalon slave/pixel source and the lt24 conduit pins.

Parameters:
WR_LOW_CYCLES, 2, clocks wr_n held low per write (>=1)
WR_HIGH_CYCLES, 2, clocks wr_n held high after each write (>=1)
RST_PULSE_CYCLES, 500, clocks lcd_reset_n held low during the init sequence (>=1)
RST_WAIT_CYCLES, 6000000, clocks to wait after lcd_reset_n rises before accepting traffic (>=1)
CNT_W, 24, timing counter width; must hold max(RST_WAIT_CYCLES, RST_PULSE_CYCLES)

Ports:
clk  in  1  system clock
reset_n  in  1  reset
init_start  in  1  single-cycle pulse; restarts the LCD reset sequence
cmd_valid  in  1  command word available
cmd_ready  out  1  command word accepted this cycle when high with cmd_valid
cmd_data  in  16  command/parameter word
cmd_is_param  in  1  0 = command (dc_n=0), 1 = parameter (dc_n=1)
pix_valid  in  1  pixel word available
pix_ready  out  1  pixel accepted this cycle when high with pix_valid
pix_data  in  16  RGB565 pixel
pix_last  in  1  qualifies pix_data as the last pixel of the burst
busy  out  1  high whenever state != IDLE
init_done  out  1  high once the reset sequence has completed
lcd_on  out  1  LCD power/backlight enable
lcd_reset_n  out  1  LCD hardware reset, active low
cs_n  out  1  chip select, active low
wr_n  out  1  write strobe, active low
rd_n  out  1  read strobe; constant 1
dc_n  out  1  0 = command, 1 = data
d  out  16  bus data

Behaviour:
- Clocking and reset: single clock clk. Reset is asynchronous, active-low: reset_n.
- Reset values:
  - state = RST_LOW; counter = 0; burst_lock = 0;
  - cs_n = wr_n = rd_n = dc_n = 1; d = 0;
  - lcd_reset_n = 0; lcd_on = 0; init_done = 0;
  - cmd_ready = pix_ready = 0; busy = 1.
- States:
  - RST_LOW: lcd_on = 1, lcd_reset_n = 0. After RST_PULSE_CYCLES clocks -> RST_WAIT.
  - RST_WAIT: lcd_reset_n = 1. After RST_WAIT_CYCLES clocks -> IDLE; set init_done = 1.
  - IDLE: readys combinational, asserted only in IDLE:
    - burst_lock = 1: pix_ready = 1, cmd_ready = 0.
    - else cmd_ready = 1, pix_ready = !cmd_valid (command has fixed priority between bursts).
    - On accept, register d and dc_n (cmd: dc_n = cmd_is_param; pix: dc_n = 1), set cs_n = 0, wr_n = 0 -> WR_LOW.
    - On pixel accept: burst_lock <= !pix_last.
  - WR_LOW: wr_n = 0 for WR_LOW_CYCLES clocks, then wr_n = 1 -> WR_HIGH.
  - WR_HIGH: wr_n = 1 for WR_HIGH_CYCLES clocks -> IDLE.
- Write-cycle timing:
  - Accept at cycle T; wr_n low during T+1 .. T+WR_LOW_CYCLES; rising edge at T+WR_LOW_CYCLES+1 (d/dc_n stable across it).
  - Next accept possible at T+WR_LOW_CYCLES+WR_HIGH_CYCLES+1.
  - Sustained throughput: one word per WR_LOW_CYCLES+WR_HIGH_CYCLES+1 clocks.
- d and dc_n hold their last value until the next accept.
- cs_n:
  - 0 from accept through the end of WR_HIGH.
  - In IDLE: cs_n = !burst_lock, i.e. held low across a pixel burst and returned to 1 in the first IDLE cycle after the last word.
- init_start:
  - Honoured in IDLE and WR_HIGH only; ignored in RST_LOW/RST_WAIT/WR_LOW.
  - In IDLE it takes priority over a simultaneous valid (no accept that cycle).
  - When honoured: -> RST_LOW, clear init_done and burst_lock, set cs_n = 1, counter = 0.
  - An in-flight WR_HIGH is truncated.
  - Pending requesters are not dropped; they wait.
- No read cycles are generated: rd_n stays 1.
- Pixel stream stalls (pix_valid low while burst_lock = 1) hold IDLE with cs_n = 0; commands stay blocked until pix_last.
- Asynchronous reset mid-write returns all outputs to their reset values immediately.

Test Plan:
Use WR_LOW_CYCLES=2, WR_HIGH_CYCLES=1, RST_PULSE_CYCLES=4, RST_WAIT_CYCLES=8.
- Power-up:
  - Stimulus: release reset_n.
  - Required: lcd_reset_n low 4 clocks, then high; init_done rises 8 clocks later; cmd_ready low throughout; rd_n = 1 always.
- Single command:
  - Stimulus: cmd 0x002C, cmd_is_param = 0.
  - Required: dc_n = 0, d = 0x002C; wr_n low exactly 2 clocks; cs_n low 4 clocks total (accept cycle + 2 low + 1 high); next cmd_ready 4 clocks after accept.
- Parameter followed by 3-pixel burst:
  - Stimulus: parameter 0x00EF, then pixels 0xF800, 0x07E0, 0x001F (pix_last on the 3rd).
  - Required: dc_n = 1 for all; cs_n stays 0 between pixel writes; cs_n returns to 1 after the 3rd write.
- Arbitration:
  - Stimulus: cmd_valid and pix_valid asserted together in IDLE.
  - Required: command is written first.
  - Stimulus: a command arrives mid-burst.
  - Required: cmd_ready stays 0 until pix_last has been written.
- Re-init:
  - Stimulus: init_start in IDLE with cmd_valid high.
  - Required: no accept that cycle; init_done = 0; lcd_reset_n low 4 clocks; the command is accepted only after init_done returns to 1.
- Async reset:
  - Stimulus: assert reset_n during WR_LOW.
  - Required: wr_n, cs_n, and dc_n go to 1 and d = 0 without waiting for a clock edge.
